// File: rtl/frame_monitor.sv
// frame_monitor: parses a 16-bit AXI-Stream framed protocol (preamble, MAC
// header, length, type, payload), validates framing and length, checksums
// the payload, and exposes counters and last-good-frame info on a byte-wide
// Avalon-MM slave.
module frame_monitor #(
  parameter int MAX_LEN = 1500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ingress_port_tdata,
  input  logic        ingress_port_tvalid,
  input  logic        ingress_port_tlast,
  output logic        ingress_port_tready,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [15:0] SAT       = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0, ERR_PREAMBLE = 2'd1, ERR_LENGTH = 2'd2, ERR_TRUNC = 2'd3
  } err_code_t;

  // Parser state
  state_t      state;
  logic [3:0]  word_idx;     // position within preamble/header, word 0 = first AAAA
  logic [47:0] dst_mac;      // byte 0 (first on the wire) in bits [7:0]
  logic [15:0] len;
  logic [15:0] beats_left;   // payload beats still expected, including the current one
  logic [31:0] csum;

  // Register file
  logic        enable;
  logic [15:0] frames_ok, frames_err, junk;
  logic        status_err;
  logic [1:0]  status_code;
  logic [47:0] last_dst;
  logic [15:0] last_len;
  logic [31:0] last_csum;

  // Per-beat decisions
  logic        xfer;
  logic        clear;
  logic        ev_ok, ev_err, ev_junk;
  err_code_t   ev_code;
  state_t      next_state;
  logic        last_beat;
  logic [31:0] beat_sum, csum_next;
  logic [15:0] hdr_len;
  logic [16:0] len_plus;
  logic        unused_wdata;

  assign ingress_port_tready = enable;
  assign xfer         = ingress_port_tvalid && enable;
  assign clear        = chipselect && write && (address == 8'd0) && writedata[1];
  assign hdr_len      = {ingress_port_tdata[7:0], ingress_port_tdata[15:8]};
  assign len_plus     = {1'b0, len} + 17'd1;
  assign unused_wdata = ^writedata[7:2];

  // Classify the current beat: next state and the ok/error/junk events it raises
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    next_state = state;
    ev_ok      = 1'b0;
    ev_err     = 1'b0;
    ev_junk    = 1'b0;
    ev_code    = ERR_NONE;
    last_beat  = (beats_left == 16'd1);
    beat_sum   = {24'd0, ingress_port_tdata[15:8]}
               + ((last_beat && len[0]) ? 32'd0 : {24'd0, ingress_port_tdata[7:0]});
    csum_next  = csum + beat_sum;
    if (xfer) begin
      case (state)
        S_IDLE: begin
          if (ingress_port_tdata == 16'hAAAA) next_state = S_PREAMBLE;
          else                                ev_junk    = 1'b1;
        end
        S_PREAMBLE: begin
          if (ingress_port_tdata != ((word_idx == 4'd3) ? 16'hAAAB : 16'hAAAA)) begin
            ev_err  = 1'b1;
            ev_code = ERR_PREAMBLE;
          end else if (ingress_port_tlast) begin
            ev_err  = 1'b1;
            ev_code = ERR_TRUNC;
          end else if (word_idx == 4'd3) begin
            next_state = S_HEADER;
          end
        end
        S_HEADER: begin
          if (word_idx == 4'd11) begin
            if (len > MAX_LEN_W) begin
              ev_err  = 1'b1;
              ev_code = ERR_LENGTH;
            end else if (len == 16'd0) begin
              if (ingress_port_tlast) ev_ok = 1'b1;
              else begin
                ev_err  = 1'b1;
                ev_code = ERR_LENGTH;
              end
            end else if (ingress_port_tlast) begin
              ev_err  = 1'b1;
              ev_code = ERR_TRUNC;
            end else begin
              next_state = S_PAYLOAD;
            end
          end else if (ingress_port_tlast) begin
            ev_err  = 1'b1;
            ev_code = ERR_TRUNC;
          end
        end
        S_PAYLOAD: begin
          if (last_beat) begin
            if (ingress_port_tlast) ev_ok = 1'b1;
            else begin
              ev_err  = 1'b1;
              ev_code = ERR_LENGTH;
            end
          end else if (ingress_port_tlast) begin
            ev_err  = 1'b1;
            ev_code = ERR_LENGTH;
          end
        end
        S_DRAIN: begin
          if (ingress_port_tlast) next_state = S_IDLE;
        end
        default: next_state = S_IDLE;
      endcase
      if (ev_ok)  next_state = S_IDLE;
      if (ev_err) next_state = ingress_port_tlast ? S_IDLE : S_DRAIN;
    end
  end

  // Parser FSM and header/payload capture; advances only on accepted beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      word_idx   <= 4'd0;
      dst_mac    <= 48'd0;
      len        <= 16'd0;
      beats_left <= 16'd0;
      csum       <= 32'd0;
    end else if (xfer) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state    <= next_state;
      word_idx <= word_idx + 4'd1;
      case (state)
        S_IDLE: begin
          word_idx <= 4'd1;
          csum     <= 32'd0;
        end
        S_HEADER: begin
          case (word_idx)
            4'd4:  dst_mac[15:0]  <= {ingress_port_tdata[7:0], ingress_port_tdata[15:8]};
            4'd5:  dst_mac[31:16] <= {ingress_port_tdata[7:0], ingress_port_tdata[15:8]};
            4'd6:  dst_mac[47:32] <= {ingress_port_tdata[7:0], ingress_port_tdata[15:8]};
            4'd10: len            <= hdr_len;
            4'd11: beats_left     <= len_plus[16:1];
            default: ;
          endcase
        end
        S_PAYLOAD: begin
          csum       <= csum_next;
          beats_left <= beats_left - 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Control, saturating counters, status and last-good-frame registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable      <= 1'b0;
      frames_ok   <= 16'd0;
      frames_err  <= 16'd0;
      junk        <= 16'd0;
      status_err  <= 1'b0;
      status_code <= 2'd0;
      last_dst    <= 48'd0;
      last_len    <= 16'd0;
      last_csum   <= 32'd0;
    end else begin
      if (chipselect && write && address == 8'd0) enable <= writedata[0];
      if (clear) begin
        frames_ok   <= 16'd0;
        frames_err  <= 16'd0;
        junk        <= 16'd0;
        status_err  <= 1'b0;
        status_code <= 2'd0;
      end else begin
        if (ev_junk && junk != SAT) junk <= junk + 16'd1;
        if (ev_ok) begin
          if (frames_ok != SAT) frames_ok <= frames_ok + 16'd1;
          status_err  <= 1'b0;
          status_code <= 2'd0;
        end
        if (ev_err) begin
          if (frames_err != SAT) frames_err <= frames_err + 16'd1;
          status_err  <= 1'b1;
          status_code <= ev_code;
        end
      end
      // Frame-info latches are not counters; clear leaves them alone
      if (ev_ok) begin
        last_dst  <= dst_mac;
        last_len  <= len;
        last_csum <= (state == S_PAYLOAD) ? csum_next : csum;
      end
    end
  end

  // Registered read port; returns 0 on cycles without a read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 8'd0;
    end else if (chipselect && read) begin
      case (address)
        8'd0:    readdata <= {7'd0, enable};
        8'd1:    readdata <= {4'd0, status_code, status_err, state != S_IDLE};
        8'd2:    readdata <= frames_ok[7:0];
        8'd3:    readdata <= frames_ok[15:8];
        8'd4:    readdata <= frames_err[7:0];
        8'd5:    readdata <= frames_err[15:8];
        8'd6:    readdata <= junk[7:0];
        8'd7:    readdata <= junk[15:8];
        8'd8:    readdata <= last_dst[7:0];
        8'd9:    readdata <= last_dst[15:8];
        8'd10:   readdata <= last_dst[23:16];
        8'd11:   readdata <= last_dst[31:24];
        8'd12:   readdata <= last_dst[39:32];
        8'd13:   readdata <= last_dst[47:40];
        8'd14:   readdata <= last_len[7:0];
        8'd15:   readdata <= last_len[15:8];
        8'd16:   readdata <= last_csum[7:0];
        8'd17:   readdata <= last_csum[15:8];
        8'd18:   readdata <= last_csum[23:16];
        8'd19:   readdata <= last_csum[31:24];
        default: readdata <= 8'd0;
      endcase
    end else begin
      readdata <= 8'd0;
    end
  end

endmodule

// File: tb/tb_frame_monitor.sv
// Directed testbench for frame_monitor: framed stream stimulus plus Avalon
// register reads, with hand-computed expected values.
module tb_frame_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ingress_port_tdata = 16'd0;
  logic        ingress_port_tvalid = 1'b0;
  logic        ingress_port_tlast = 1'b0;
  logic        ingress_port_tready;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [7:0]  address = 8'd0;
  logic [7:0]  writedata = 8'd0;
  logic [7:0]  readdata;

  int errors = 0;
  int checks = 0;
  logic [15:0] q[$];
  logic [31:0] v;
  logic [7:0]  b;

  frame_monitor #(.MAX_LEN(1500)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ingress_port_tdata  (ingress_port_tdata),
    .ingress_port_tvalid (ingress_port_tvalid),
    .ingress_port_tlast  (ingress_port_tlast),
    .ingress_port_tready (ingress_port_tready),
    .chipselect          (chipselect),
    .write               (write),
    .read                (read),
    .address             (address),
    .writedata           (writedata),
    .readdata            (readdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  // Little-endian multi-byte read
  task automatic rdn(input logic [7:0] a, input int n, output logic [31:0] val);
    logic [7:0] t;
    val = 32'd0;
    for (int i = 0; i < n; i++) begin
      rd(a + 8'(i), t);
      val[8*i +: 8] = t;
    end
  endtask

  // One beat, waiting (bounded) for tready
  task automatic beat(input logic [15:0] d, input logic l);
    int waited;
    waited = 0;
    ingress_port_tdata = d; ingress_port_tlast = l; ingress_port_tvalid = 1'b1;
    while (!ingress_port_tready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) check("beat_accept_timeout", {31'd0, ingress_port_tready}, 32'd1);
    @(posedge clk); #1;
    ingress_port_tvalid = 1'b0; ingress_port_tlast = 1'b0;
  endtask

  // Standard header: dst 00:11:22:33:44:55, src 66:77:88:99:AA:BB, type 0800
  task automatic build_header(input logic [15:0] length);
    q.delete();
    q.push_back(16'hAAAA); q.push_back(16'hAAAA); q.push_back(16'hAAAA); q.push_back(16'hAAAB);
    q.push_back(16'h0011); q.push_back(16'h2233); q.push_back(16'h4455);
    q.push_back(16'h6677); q.push_back(16'h8899); q.push_back(16'hAABB);
    q.push_back({length[7:0], length[15:8]});
    q.push_back(16'h0800);
  endtask

  // Send q[from..to], with tlast on index last_at
  task automatic send_range(input int from, input int to, input int last_at);
    for (int i = from; i <= to; i++) beat(q[i], i == last_at);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_tready", {31'd0, ingress_port_tready}, 32'd0);
    check("reset_readdata", {24'd0, readdata}, 32'd0);
    rd(8'd0, b);  check("reset_ctrl", {24'd0, b}, 32'd0);
    rd(8'd1, b);  check("reset_status", {24'd0, b}, 32'd0);
    rdn(8'd2, 2, v); check("reset_frames_ok", v, 32'd0);
    @(posedge clk); #1;
    check("readdata_idle_zero", {24'd0, readdata}, 32'd0);

    // Enable; writes to unused addresses are ignored
    wr(8'd0, 8'h01);
    wr(8'h30, 8'hFF);
    check("tready_enabled", {31'd0, ingress_port_tready}, 32'd1);
    rd(8'h30, b); check("unused_addr_reads_zero", {24'd0, b}, 32'd0);
    rd(8'd0, b);  check("ctrl_enable", {24'd0, b}, 32'd1);

    // Good frame, len=4: csum 1+2+3+4 = 10
    build_header(16'd4); q.push_back(16'h0102); q.push_back(16'h0304);
    send_range(0, q.size() - 1, q.size() - 1);
    rdn(8'd2, 2, v);  check("good4_frames_ok", v, 32'd1);
    rdn(8'd14, 2, v); check("good4_last_len", v, 32'd4);
    rdn(8'd16, 4, v); check("good4_last_csum", v, 32'd10);
    rd(8'd1, b);      check("good4_status", {24'd0, b}, 32'd0);
    rdn(8'd8, 4, v);  check("good4_dst_lo", v, 32'h33221100);
    rd(8'd13, b);     check("good4_dst_byte5", {24'd0, b}, 32'h55);

    // Odd length, len=3: low byte of last beat excluded -> 1+2+3 = 6
    build_header(16'd3); q.push_back(16'h0102); q.push_back(16'h03FF);
    send_range(0, q.size() - 1, q.size() - 1);
    rdn(8'd2, 2, v);  check("odd3_frames_ok", v, 32'd2);
    rdn(8'd16, 4, v); check("odd3_last_csum", v, 32'd6);
    rdn(8'd14, 2, v); check("odd3_last_len", v, 32'd3);

    // Preamble error: word 3 = AAAA, then 10 beats with tlast on the last
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(16'hAAAA);
    for (int i = 0; i < 10; i++) q.push_back(16'h1000 + 16'(i));
    send_range(0, q.size() - 1, q.size() - 1);
    rdn(8'd4, 2, v);  check("pre_frames_err", v, 32'd1);
    rd(8'd1, b);      check("pre_status_code1_idle", {24'd0, b}, 32'h06);
    rdn(8'd6, 2, v);  check("pre_no_junk", v, 32'd0);
    rdn(8'd14, 2, v); check("pre_last_len_kept", v, 32'd3);

    // len=4 with tlast on the first payload beat: early tlast
    build_header(16'd4); q.push_back(16'h0102);
    send_range(0, q.size() - 1, q.size() - 1);
    rdn(8'd4, 2, v);  check("early_frames_err", v, 32'd2);
    rd(8'd1, b);      check("early_status_code2", {24'd0, b}, 32'h0A);

    // len=1600 exceeds MAX_LEN: error at word 11, then drained
    build_header(16'd1600);
    q.push_back(16'h1111); q.push_back(16'h2222); q.push_back(16'h3333);
    send_range(0, 11, -1);
    rd(8'd1, b);      check("long_status_draining", {24'd0, b}, 32'h0B);
    send_range(12, q.size() - 1, q.size() - 1);
    rdn(8'd4, 2, v);  check("long_frames_err", v, 32'd3);
    rd(8'd1, b);      check("long_status_idle", {24'd0, b}, 32'h0A);
    rdn(8'd6, 2, v);  check("long_no_junk", v, 32'd0);

    // Junk between frames, then a good len=2 frame
    for (int i = 0; i < 3; i++) beat(16'h0000, 1'b0);
    rdn(8'd6, 2, v);  check("junk_count", v, 32'd3);
    build_header(16'd2); q.push_back(16'h1020);
    send_range(0, q.size() - 1, q.size() - 1);
    rdn(8'd2, 2, v);  check("after_junk_frames_ok", v, 32'd3);
    rdn(8'd16, 4, v); check("after_junk_csum", v, 32'h30);
    rd(8'd1, b);      check("after_junk_status", {24'd0, b}, 32'd0);

    // Zero-length frame completes on word 11
    build_header(16'd0);
    send_range(0, q.size() - 1, q.size() - 1);
    rdn(8'd2, 2, v);  check("len0_frames_ok", v, 32'd4);
    rdn(8'd14, 2, v); check("len0_last_len", v, 32'd0);
    rdn(8'd16, 4, v); check("len0_last_csum", v, 32'd0);

    // Maximum legal length: 750 beats of 0101 -> csum 1500
    build_header(16'd1500);
    for (int i = 0; i < 750; i++) q.push_back(16'h0101);
    send_range(0, q.size() - 1, q.size() - 1);
    rdn(8'd2, 2, v);  check("max_frames_ok", v, 32'd5);
    rdn(8'd16, 4, v); check("max_last_csum", v, 32'd1500);
    rdn(8'd14, 2, v); check("max_last_len", v, 32'd1500);

    // Stall mid-frame by dropping enable, then resume
    build_header(16'd2); q.push_back(16'h1020);
    send_range(0, 5, -1);
    wr(8'd0, 8'h00);
    ingress_port_tdata = q[6]; ingress_port_tlast = 1'b0; ingress_port_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stall_tready_low", {31'd0, ingress_port_tready}, 32'd0);
    rd(8'd1, b);      check("stall_status_busy", {24'd0, b}, 32'h01);
    wr(8'd0, 8'h01);
    send_range(6, q.size() - 1, q.size() - 1);
    rdn(8'd2, 2, v);  check("stall_frames_ok", v, 32'd6);
    rdn(8'd4, 2, v);  check("stall_frames_err", v, 32'd3);

    // Clear during a frame: counters zeroed, frame still counted at completion
    build_header(16'd4); q.push_back(16'h0102); q.push_back(16'h0304);
    send_range(0, 7, -1);
    wr(8'd0, 8'h03);
    rd(8'd0, b);      check("clear_ctrl_reads", {24'd0, b}, 32'd1);
    rdn(8'd2, 2, v);  check("clear_frames_ok", v, 32'd0);
    rdn(8'd4, 2, v);  check("clear_frames_err", v, 32'd0);
    rdn(8'd6, 2, v);  check("clear_junk", v, 32'd0);
    rd(8'd1, b);      check("clear_status_busy_only", {24'd0, b}, 32'h01);
    rdn(8'd14, 2, v); check("clear_last_len_kept", v, 32'd2);
    send_range(8, q.size() - 1, q.size() - 1);
    rdn(8'd2, 2, v);  check("clear_inflight_counted", v, 32'd1);
    rdn(8'd16, 4, v); check("clear_inflight_csum", v, 32'd10);

    // Reset at word 6, then a full good frame
    build_header(16'd4); q.push_back(16'h0102); q.push_back(16'h0304);
    send_range(0, 5, -1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_tready_low", {31'd0, ingress_port_tready}, 32'd0);
    rdn(8'd14, 2, v); check("rst_last_len_zero", v, 32'd0);
    wr(8'd0, 8'h01);
    send_range(0, q.size() - 1, q.size() - 1);
    rdn(8'd2, 2, v);  check("rst_frames_ok", v, 32'd1);
    rdn(8'd4, 2, v);  check("rst_frames_err", v, 32'd0);
    rdn(8'd6, 2, v);  check("rst_junk", v, 32'd0);
    rdn(8'd16, 4, v); check("rst_last_csum", v, 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
